// File: rtl/entry_checker.sv
// Parking gate entry checker: grants a timed gate-open window or denies when the lot is full.
// Optional statistics outputs (grant_cnt, deny_cnt) are enabled by defining ENTRY_CHECKER_STATS_EN.
module entry_checker #(
    parameter int unsigned CAP_W       = 8,
    parameter int unsigned OPEN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry,
    input  logic [CAP_W-1:0] parking_capacity,
    output logic             enable,
    output logic             full,
    output logic             deny
`ifdef ENTRY_CHECKER_STATS_EN
    ,
    output logic [15:0]      grant_cnt,
    output logic [15:0]      deny_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        WAIT_CLEAR
    } state_t;

    // Counter is preloaded with OPEN_CYCLES-1 on the grant edge, which already drives enable high.
    localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       enable_next;
    logic       deny_next;
    logic       grant_evt;
    logic       cap_zero;

    assign cap_zero = (parking_capacity == '0);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        enable_next = 1'b0;
        deny_next   = 1'b0;
        grant_evt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (entry) begin
                    if (cap_zero) begin
                        state_next = WAIT_CLEAR;
                        deny_next  = 1'b1;
                    end else begin
                        state_next  = OPEN;
                        enable_next = 1'b1;
                        cnt_next    = OPEN_LOAD;
                        grant_evt   = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (cnt == '0) begin
                    state_next = WAIT_CLEAR;
                end else begin
                    cnt_next    = cnt - 8'd1;
                    enable_next = 1'b1;
                end
            end
            WAIT_CLEAR: begin
                if (!entry) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            enable <= 1'b0;
            deny   <= 1'b0;
            full   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            enable <= enable_next;
            deny   <= deny_next;
            full   <= cap_zero;
        end
    end

`ifdef ENTRY_CHECKER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
            deny_cnt  <= '0;
        end else begin
            if (grant_evt && (grant_cnt != '1)) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
            if (deny_next && (deny_cnt != '1)) begin
                deny_cnt <= deny_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_entry_checker.sv
// Directed and randomized bench for entry_checker against a cycle-indexed behavioural model.
module tb_entry_checker;

    localparam int OPEN = 4;

    logic       clk;
    logic       rst;
    logic       entry;
    logic [7:0] parking_capacity;
    logic       enable;
    logic       full;
    logic       deny;
`ifdef ENTRY_CHECKER_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] deny_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Model: the window is described by the edge index of the grant, not by a countdown.
    int   n = 0;
    int   m_grant_edge = 0;
    int   m_deny_edge = -1;
    bit   m_open = 0;
    bit   m_wait = 0;
    bit   m_full = 0;
    int   m_grants = 0;
    int   m_denies = 0;

    entry_checker #(
        .CAP_W       (8),
        .OPEN_CYCLES (OPEN)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .entry            (entry),
        .parking_capacity (parking_capacity),
        .enable           (enable),
        .full             (full),
        .deny             (deny)
`ifdef ENTRY_CHECKER_STATS_EN
        ,
        .grant_cnt        (grant_cnt),
        .deny_cnt         (deny_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open      = 0;
        m_wait      = 0;
        m_full      = 0;
        m_deny_edge = -1;
        m_grants    = 0;
        m_denies    = 0;
    endtask

    task automatic model_edge();
        n++;
        if (rst) begin
            model_reset();
        end else begin
            m_full = (parking_capacity == 0);
            if (m_open) begin
                if (n - m_grant_edge >= OPEN) begin
                    m_open = 0;
                    m_wait = 1;
                end
            end else if (m_wait) begin
                if (!entry) m_wait = 0;
            end else if (entry) begin
                if (parking_capacity != 0) begin
                    m_open       = 1;
                    m_grant_edge = n;
                    if (m_grants < 65535) m_grants++;
                end else begin
                    m_wait      = 1;
                    m_deny_edge = n;
                    if (m_denies < 65535) m_denies++;
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".enable"}, {15'b0, enable}, {15'b0, m_open});
        check({where, ".deny"}, {15'b0, deny}, {15'b0, (m_deny_edge == n) && !rst});
        check({where, ".full"}, {15'b0, full}, {15'b0, m_full});
        check({where, ".excl"}, {15'b0, enable & deny}, 16'h0);
`ifdef ENTRY_CHECKER_STATS_EN
        check({where, ".grant_cnt"}, grant_cnt, 16'(m_grants));
        check({where, ".deny_cnt"}, deny_cnt, 16'(m_denies));
`endif
    endtask

    task automatic step(input string where, input logic r, input logic e, input logic [7:0] c);
        @(negedge clk);
        rst              = r;
        entry            = e;
        parking_capacity = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(where);
    endtask

    initial begin
        rst              = 1'b0;
        entry            = 1'b0;
        parking_capacity = 8'h00;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        step("reset_hold", 1'b1, 1'b1, 8'h00);
        step("reset_hold", 1'b1, 1'b1, 8'h05);
        step("reset_rel", 1'b0, 1'b0, 8'h03);

        // Full lot: one deny pulse, then held in wait until entry drops.
        for (int i = 0; i < 5; i++) step("deny_full", 1'b0, 1'b1, 8'h00);
        step("deny_clear", 1'b0, 1'b0, 8'h00);
        step("deny_idle", 1'b0, 1'b0, 8'h00);

        // Grant with entry held high: exactly OPEN enable cycles, then waits.
        for (int i = 0; i < 8; i++) step("grant_hold", 1'b0, 1'b1, 8'h02);
        step("grant_clear", 1'b0, 1'b0, 8'h02);

        // No request: nothing happens, full follows capacity.
        for (int i = 0; i < 3; i++) step("idle_cap2", 1'b0, 1'b0, 8'h02);
        for (int i = 0; i < 3; i++) step("idle_cap0", 1'b0, 1'b0, 8'h00);

        // Inputs changed during the open window are ignored.
        step("ignore_req", 1'b0, 1'b1, 8'h02);
        for (int i = 0; i < 6; i++) step("ignore_win", 1'b0, 1'b0, 8'h00);
        step("ignore_reentry", 1'b0, 1'b1, 8'h00);
        step("ignore_clear", 1'b0, 1'b0, 8'h00);

        // Boundary capacities.
        step("cap_max", 1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 5; i++) step("cap_max_win", 1'b0, 1'b0, 8'hFF);
        step("cap_one", 1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 5; i++) step("cap_one_win", 1'b0, 1'b0, 8'h01);

        // Asynchronous reset in the second cycle of the window.
        step("mid_grant", 1'b0, 1'b1, 8'h01);
        step("mid_open2", 1'b0, 1'b1, 8'h01);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst_async");
        step("mid_rst_hold", 1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 6; i++) step("mid_regrant", 1'b0, 1'b1, 8'h01);
        step("mid_clear", 1'b0, 1'b0, 8'h01);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic       e;
            logic [7:0] c;
            e = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0:       c = 8'h00;
                1:       c = 8'h01;
                2:       c = 8'hFF;
                default: c = 8'($urandom);
            endcase
            step("rand", 1'b0, e, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/entry_checker.md
ENTRY_CHECKER -- requirements
Module: entry_checker

Interface
REQ-001 Parameter CAP_W, default 8, width of the parking_capacity input.
REQ-002 Parameter OPEN_CYCLES, default 4, number of clock cycles enable is held high per granted entry; legal range 1..255.
REQ-003 Port clk  input  1  single system clock, rising-edge active.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port entry  input  1  car-at-gate request, synchronous to clk, level-sensitive.
REQ-006 Port parking_capacity  input  CAP_W  free spaces remaining, unsigned; 0 means lot full.
REQ-007 Port enable  output  1  gate-open command, registered.
REQ-008 Port full  output  1  registered flag, high when parking_capacity == 0.
REQ-009 Port deny  output  1  registered one-cycle pulse on a refused request.
REQ-010 The block SHALL have one clock; reset SHALL be asynchronous and active-high, on ports clk and rst.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, OPEN, WAIT_CLEAR; all outputs registered.
REQ-012 In IDLE with entry=1 and parking_capacity != 0 at a rising edge, the FSM SHALL go to OPEN and enable SHALL be 1 from that edge (1-cycle latency from sampled request).
REQ-013 In IDLE with entry=1 and parking_capacity == 0, the FSM SHALL go to WAIT_CLEAR and deny SHALL be 1 for exactly one cycle; enable stays 0.
REQ-014 In IDLE with entry=0, the FSM SHALL stay in IDLE with enable=0, deny=0.
REQ-015 In OPEN, enable SHALL remain 1 for exactly OPEN_CYCLES cycles, counted by an internal down-counter, then the FSM SHALL go to WAIT_CLEAR.
REQ-016 In OPEN, changes on entry or parking_capacity SHALL be ignored; the open window always completes.
REQ-017 In WAIT_CLEAR, enable=0; the FSM SHALL return to IDLE on the first edge sampling entry=0 (one grant or deny per request).
REQ-018 full SHALL be updated every cycle from (parking_capacity == 0), independent of FSM state.
REQ-019 Boundary: parking_capacity = 1 and = 2^CAP_W-1 SHALL both grant; only exactly 0 denies.
REQ-020 enable and deny SHALL never be 1 in the same cycle.
REQ-021 The block SHALL not modify or track capacity itself; decrementing is the caller's responsibility.

Reset
REQ-022 While rst=1, state SHALL be IDLE, enable=0, deny=0, full=0, open counter=0, and all statistics counters 0, regardless of clk.
REQ-023 Reset asserted mid-OPEN SHALL drop enable immediately (asynchronously); after release, a still-high entry SHALL be evaluated as a new request in IDLE.

Configuration
REQ-024 Macro ENTRY_CHECKER_STATS_EN SHALL, when defined, add outputs grant_cnt[15:0] and deny_cnt[15:0].
REQ-025 With the macro, grant_cnt SHALL increment on each IDLE->OPEN transition and deny_cnt on each deny pulse, both saturating at 16'hFFFF and cleared by rst.
REQ-026 Without the macro, these ports and their logic SHALL be absent; all other behaviour identical.

Verification (OPEN_CYCLES=4, CAP_W=8)
REQ-027 entry=1, parking_capacity=8'h00 after reset -> full=1 next edge, deny=1 for one cycle, enable stays 0; remains in WAIT_CLEAR until entry=0.
REQ-028 entry=1, parking_capacity=8'h02 -> enable=1 for exactly 4 cycles starting next edge, then 0 while entry held 1; deny never 1.
REQ-029 entry=0, parking_capacity=8'h02 or 8'h00 -> enable=0, deny=0 indefinitely; full follows capacity.
REQ-030 Grant with entry dropped after 1 cycle and capacity set to 8'h00 during OPEN -> enable still 4 cycles, then IDLE after one WAIT_CLEAR cycle.
REQ-031 rst pulsed on 2nd cycle of OPEN -> enable=0 immediately; with entry=1, capacity=8'h01 after release -> new 4-cycle grant.
REQ-032 With ENTRY_CHECKER_STATS_EN: 3 grants and 2 denies -> grant_cnt=3, deny_cnt=2; forced 65536 grants -> grant_cnt holds 16'hFFFF.
